// File: rtl/qsort_wb_bridge_pkg.sv
// Shared definitions for the Wishbone front end of the stream sorter.
// Holds the register offsets, status bit positions, the default FIFO depth
// and the register decode helper.
package qsort_wb_bridge_pkg;

    localparam int unsigned FIFO_AW_DEF = 4;   // depth 16
    localparam int unsigned CNT_FIELD_W = 5;   // width of each count field in STATUS

    localparam logic [31:0] OFS_CTRL     = 32'h00;
    localparam logic [31:0] OFS_DATA_IN  = 32'h10;
    localparam logic [31:0] OFS_DATA_OUT = 32'h14;

    // STATUS read bits / CTRL write bits
    localparam int unsigned ST_IN_EMPTY    = 0;
    localparam int unsigned ST_IN_FULL     = 1;
    localparam int unsigned ST_OUT_EMPTY   = 2;
    localparam int unsigned ST_OUT_FULL    = 3;
    localparam int unsigned ST_OVERFLOW    = 4;
    localparam int unsigned ST_UNDERFLOW   = 5;
    localparam int unsigned ST_IN_CNT_LSB  = 8;
    localparam int unsigned ST_OUT_CNT_LSB = 16;
    localparam int unsigned CTRL_FLUSH     = 0;

    typedef enum logic [1:0] {
        REG_CTRL,
        REG_DATA_IN,
        REG_DATA_OUT,
        REG_OTHER
    } reg_sel_e;

    function automatic reg_sel_e decode_reg(input logic [31:0] ofs);
        case (ofs)
            OFS_CTRL:     return REG_CTRL;
            OFS_DATA_IN:  return REG_DATA_IN;
            OFS_DATA_OUT: return REG_DATA_OUT;
            default:      return REG_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/qsort_wb_bridge_stream_fifo.sv
// stream_fifo: first-word-fall-through FIFO with fill count and synchronous
// flush. Full/empty are evaluated on the current state, so a push at full or
// a pop at empty is rejected regardless of the opposite same-cycle operation.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush_i       clears pointers and count (contents untouched)
//   push_i/wdata_i  write request and data
//   pop_i         read request; rdata_o always shows the head
//   full_o, empty_o, count_o  occupancy (count 0..2**AW)
module stream_fifo #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; a flush or reset only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/qsort_wb_bridge.sv
// qsort_wb_bridge: Wishbone classic slave that feeds the stream sorter from
// an input FIFO and collects its sorted output in an output FIFO.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i/sel_i     Wishbone control (sel ignored, full-word only)
//   wbs_adr_i, wbs_dat_i           byte offset and write data
//   wbs_ack_o, wbs_dat_o           registered single-cycle ack and read data
//   sm_tvalid/sm_tdata/sm_tready   AXI-Stream master towards the sorter
//   ss_tvalid/ss_tdata/ss_tready   AXI-Stream slave from the sorter
// Registers: 0x00 CTRL/STATUS, 0x10 DATA_IN, 0x14 DATA_OUT.
module qsort_wb_bridge
    import qsort_wb_bridge_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned pADDR_WIDTH = 8,
    parameter int unsigned pFIFO_AW    = FIFO_AW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [pADDR_WIDTH-1:0] wbs_adr_i,
    input  logic [pDATA_WIDTH-1:0] wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [pDATA_WIDTH-1:0] wbs_dat_o,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tready,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tready
);

    logic                   ack_q, ack_d;
    logic [pDATA_WIDTH-1:0] dat_q, dat_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;

    logic       accept, rd, wr, ctrl_wr, flush, in_push, in_pop, out_push, out_pop;
    reg_sel_e   sel;
    logic [31:0] status;

    logic                   in_full, in_empty, out_full, out_empty;
    logic [pFIFO_AW:0]      in_count, out_count;
    logic [pDATA_WIDTH-1:0] in_rdata, out_rdata;

    logic unused_sel;
    assign unused_sel = ^wbs_sel_i;

    assign accept  = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign sel     = decode_reg(32'(wbs_adr_i));
    assign wr      = accept & wbs_we_i;
    assign rd      = accept & ~wbs_we_i;
    assign ctrl_wr = wr & (sel == REG_CTRL);
    assign flush   = ctrl_wr & wbs_dat_i[CTRL_FLUSH];
    assign in_push = wr & (sel == REG_DATA_IN);
    assign out_pop = rd & (sel == REG_DATA_OUT);

    assign sm_tvalid = ~in_empty;
    assign sm_tdata  = in_rdata;
    assign in_pop    = sm_tvalid & sm_tready;
    assign ss_tready = ~out_full & ~rst;
    assign out_push  = ss_tvalid & ss_tready;

    stream_fifo #(.DW(pDATA_WIDTH), .AW(pFIFO_AW)) u_in_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (in_push),
        .wdata_i (wbs_dat_i),
        .pop_i   (in_pop),
        .rdata_o (in_rdata),
        .full_o  (in_full),
        .empty_o (in_empty),
        .count_o (in_count)
    );

    stream_fifo #(.DW(pDATA_WIDTH), .AW(pFIFO_AW)) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (out_push),
        .wdata_i (ss_tdata),
        .pop_i   (out_pop),
        .rdata_o (out_rdata),
        .full_o  (out_full),
        .empty_o (out_empty),
        .count_o (out_count)
    );

    always_comb begin
        status = '0;
        status[ST_IN_EMPTY]  = in_empty;
        status[ST_IN_FULL]   = in_full;
        status[ST_OUT_EMPTY] = out_empty;
        status[ST_OUT_FULL]  = out_full;
        status[ST_OVERFLOW]  = ovf_q;
        status[ST_UNDERFLOW] = unf_q;
        status[ST_IN_CNT_LSB  +: CNT_FIELD_W] = CNT_FIELD_W'(in_count);
        status[ST_OUT_CNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(out_count);
    end

    always_comb begin
        ack_d = accept;
        ovf_d = ovf_q;
        unf_d = unf_q;
        dat_d = '0;
        if (ctrl_wr && wbs_dat_i[ST_OVERFLOW])  ovf_d = 1'b0;
        if (ctrl_wr && wbs_dat_i[ST_UNDERFLOW]) unf_d = 1'b0;
        // Flags use the pre-edge full/empty, matching the FIFO's own rejection.
        if (in_push && in_full)   ovf_d = 1'b1;
        if (out_pop && out_empty) unf_d = 1'b1;
        if (rd) begin
            case (sel)
                REG_CTRL:     dat_d = pDATA_WIDTH'(status);
                REG_DATA_OUT: dat_d = out_empty ? '0 : out_rdata;
                default:      dat_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_qsort_wb_bridge.sv
module tb_qsort_wb_bridge;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [7:0]  wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        sm_tvalid, sm_tready = 1'b0;
    logic [31:0] sm_tdata;
    logic        ss_tvalid = 1'b0, ss_tready;
    logic [31:0] ss_tdata = '0;

    always #5 clk = ~clk;

    qsort_wb_bridge #(.pDATA_WIDTH(32), .pADDR_WIDTH(8), .pFIFO_AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .sm_tvalid (sm_tvalid),
        .sm_tdata  (sm_tdata),
        .sm_tready (sm_tready),
        .ss_tvalid (ss_tvalid),
        .ss_tdata  (ss_tdata),
        .ss_tready (ss_tready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain queues for both FIFOs, sticky flags, and a
    // sorter that emits each 10-word frame in descending order.
    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    logic [31:0] in_q[$], out_q[$], src_q[$], sort_buf[$];
    exp_t        sb[$];
    logic        ovf_m = 1'b0, unf_m = 1'b0, ack_m = 1'b0;
    bit          sorter_en = 1'b0, ss_en = 1'b0, rnd_tready = 1'b0;
    logic        sm_cmd = 1'b0;

    logic [31:0] frame[10] = '{32'h3, 32'h9, 32'h1, 32'h7, 32'h0,
                               32'h8, 32'h2, 32'h6, 32'h4, 32'h5};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] status_of(input int ni, input int no,
                                              input logic ov, input logic un);
        logic [31:0] s;
        s = (32'(ni) << 8) + (32'(no) << 16);
        if (ni == 0)     s = s + 32'h01;
        if (ni == DEPTH) s = s + 32'h02;
        if (no == 0)     s = s + 32'h04;
        if (no == DEPTH) s = s + 32'h08;
        if (ov)          s = s + 32'h10;
        if (un)          s = s + 32'h20;
        return s;
    endfunction

    // Model update on each active edge, from the pre-edge model state.
    always @(posedge clk) begin
        int          in_pre, out_pre;
        bit          acc, do_flush, sm_hs, ss_hs;
        logic [31:0] sm_word;
        exp_t        e;
        if (rst) begin
            in_q.delete();
            out_q.delete();
            sort_buf.delete();
            ovf_m <= 1'b0;
            unf_m <= 1'b0;
            ack_m <= 1'b0;
        end else begin
            in_pre   = in_q.size();
            out_pre  = out_q.size();
            do_flush = 1'b0;
            sm_hs    = sm_tready && (in_pre > 0);
            sm_word  = '0;
            if (sm_hs) sm_word = in_q[0];
            ss_hs    = ss_tvalid && (out_pre < DEPTH);
            acc      = wbs_cyc_i && wbs_stb_i && !ack_m;
            if (acc) begin
                e.is_read = !wbs_we_i;
                e.data    = '0;
                if (wbs_we_i) begin
                    if (wbs_adr_i == 8'h00) begin
                        do_flush = wbs_dat_i[0];
                        if (wbs_dat_i[4]) ovf_m <= 1'b0;
                        if (wbs_dat_i[5]) unf_m <= 1'b0;
                    end else if (wbs_adr_i == 8'h10) begin
                        if (in_pre == DEPTH) ovf_m <= 1'b1;
                        else in_q.push_back(wbs_dat_i);
                    end
                end else begin
                    if (wbs_adr_i == 8'h00) begin
                        e.data = status_of(in_pre, out_pre, ovf_m, unf_m);
                    end else if (wbs_adr_i == 8'h14) begin
                        if (out_pre == 0) unf_m <= 1'b1;
                        else e.data = out_q.pop_front();
                    end
                end
                sb.push_back(e);
            end
            ack_m <= acc;
            if (do_flush) begin
                in_q.delete();
                out_q.delete();
            end else begin
                if (sm_hs) void'(in_q.pop_front());
                if (ss_hs) out_q.push_back(ss_tdata);
            end
            if (sm_hs && sorter_en) begin
                sort_buf.push_back(sm_word);
                if (sort_buf.size() == 10) begin
                    sort_buf.rsort();
                    foreach (sort_buf[i]) src_q.push_back(sort_buf[i]);
                    sort_buf.delete();
                end
            end
            if (ss_hs) void'(src_q.pop_front());
        end
    end

    // Stream-side drivers.
    always @(negedge clk) begin
        if (rnd_tready) sm_tready = 1'($urandom_range(0, 1));
        else            sm_tready = sm_cmd;
        if (ss_en && src_q.size() > 0) begin
            ss_tvalid = 1'b1;
            ss_tdata  = src_q[0];
        end else begin
            ss_tvalid = 1'b0;
            ss_tdata  = '0;
        end
    end

    // Monitor: compares outputs against the model and pops the scoreboard on ack.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("rst_ss_tready", 32'(ss_tready), 32'd0);
            check("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
            check("rst_ack", 32'(wbs_ack_o), 32'd0);
            check("rst_dat", wbs_dat_o, 32'd0);
        end else begin
            check("ack", 32'(wbs_ack_o), 32'(ack_m));
            check("sm_tvalid", 32'(sm_tvalid), 32'(in_q.size() > 0));
            if (in_q.size() > 0) check("sm_tdata", sm_tdata, in_q[0]);
            check("ss_tready", 32'(ss_tready), 32'(out_q.size() < DEPTH));
            if (wbs_ack_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.is_read) check("rd_data", wbs_dat_o, e.data);
                end
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] d,
                           output logic [31:0] rdata);
        int n;
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wbs_ack_o && n < 8);
        checks++;
        if (!wbs_ack_o || n != 1) begin
            errors++;
            $display("FAIL ack_latency: ack=%0b after %0d cycles, expected ack after 1", wbs_ack_o, n);
        end
        rdata     = wbs_dat_o;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wait_out(input int target, input string nm);
        int n;
        n = 0;
        while (out_q.size() != target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(out_q.size()), 32'(target));
    endtask

    initial begin
        logic [31:0] rd, first_w;
        int          r;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("ss_tready_after_rst", 32'(ss_tready), 32'd1);
        wb_xfer(1'b0, 8'h00, '0, rd);
        check("status_reset", rd, 32'h0000_0005);

        // One frame through the sorter
        sorter_en = 1'b1;
        ss_en     = 1'b1;
        sm_cmd    = 1'b0;
        foreach (frame[i]) wb_xfer(1'b1, 8'h10, frame[i], rd);
        wb_xfer(1'b0, 8'h00, '0, rd);
        check("status_in10", rd, 32'h0000_0A04);
        sm_cmd = 1'b1;
        wait_out(10, "sorter_frame_timeout");
        for (int i = 0; i < 10; i++) begin
            wb_xfer(1'b0, 8'h14, '0, rd);
            check("sorted_word", rd, 32'(9 - i));
            wb_xfer(1'b0, 8'h00, '0, rd);
            check("status_out_dec", rd, (32'(9 - i) << 16) | 32'h1 | ((i == 9) ? 32'h4 : 32'h0));
        end
        sorter_en = 1'b0;

        // Input overflow
        sm_cmd = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            wb_xfer(1'b1, 8'h10, $urandom, rd);
            if (i == 15) begin
                wb_xfer(1'b0, 8'h00, '0, rd);
                check("status_in_full", rd, 32'h0000_1006);
            end
        end
        wb_xfer(1'b0, 8'h00, '0, rd);
        check("status_overflow", rd, 32'h0000_1016);
        wb_xfer(1'b1, 8'h00, 32'h10, rd);
        wb_xfer(1'b0, 8'h00, '0, rd);
        check("status_ovf_cleared", rd, 32'h0000_1006);

        // Underflow
        wb_xfer(1'b1, 8'h00, 32'h1, rd);
        wb_xfer(1'b0, 8'h14, '0, rd);
        check("underflow_data", rd, 32'h0);
        wb_xfer(1'b0, 8'h00, '0, rd);
        check("status_underflow", rd, 32'h0000_0025);
        wb_xfer(1'b1, 8'h00, 32'h20, rd);
        wb_xfer(1'b0, 8'h00, '0, rd);
        check("status_unf_cleared", rd, 32'h0000_0005);

        // Output FIFO backpressure
        first_w = $urandom;
        src_q.push_back(first_w);
        for (int i = 0; i < 16; i++) src_q.push_back($urandom);
        wait_out(16, "out_fill_timeout");
        repeat (2) @(negedge clk);
        check("ss_tready_full", 32'(ss_tready), 32'd0);
        wb_xfer(1'b0, 8'h14, '0, rd);
        check("first_out_word", rd, first_w);
        check("ss_tready_rise", 32'(ss_tready), 32'd1);
        repeat (2) @(negedge clk);
        wb_xfer(1'b0, 8'h00, '0, rd);
        check("status_out_full", rd, 32'h0010_0009);

        // Flush with both FIFOs partially filled
        wb_xfer(1'b1, 8'h00, 32'h1, rd);
        for (int i = 0; i < 5; i++) src_q.push_back($urandom);
        wait_out(5, "out_five_timeout");
        for (int i = 0; i < 5; i++) wb_xfer(1'b1, 8'h10, $urandom, rd);
        wb_xfer(1'b0, 8'h00, '0, rd);
        check("status_five_five", rd, 32'h0005_0500);
        wb_xfer(1'b1, 8'h00, 32'h1, rd);
        wb_xfer(1'b0, 8'h00, '0, rd);
        check("status_flushed", rd, 32'h0000_0005);
        check("sm_tvalid_flushed", 32'(sm_tvalid), 32'd0);

        // Randomised traffic with the sorter in the loop
        sorter_en  = 1'b1;
        rnd_tready = 1'b1;
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1, 2, 3: wb_xfer(1'b1, 8'h10, $urandom, rd);
                4, 5, 6:    wb_xfer(1'b0, 8'h14, '0, rd);
                7:          wb_xfer(1'b0, 8'h00, '0, rd);
                8:          wb_xfer(1'b1, 8'h00, $urandom & 32'h30, rd);
                9:          wb_xfer(1'b0, 8'h10, '0, rd);
                10:         wb_xfer(1'b1, 8'h14, $urandom, rd);
                default:    wb_xfer($urandom_range(0, 1) == 1, 8'(8'h20 + 4 * $urandom_range(0, 7)), $urandom, rd);
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
